// File: rtl/vend_pkg.sv
// Shared types and constants for the multi-product vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_CHANGE = 2'd2
    } vend_state_t;

    localparam int COIN_W = 2;

    localparam logic [COIN_W-1:0] COIN_ONE = 2'd1;
    localparam logic [COIN_W-1:0] COIN_TWO = 2'd2;

    function automatic logic is_legal_coin(input logic [COIN_W-1:0] v);
        return (v == COIN_ONE) || (v == COIN_TWO);
    endfunction

endpackage

// File: rtl/vend_change_out.sv
// Change payout down-counter: one unit is offered per valid/ready handshake.
module vend_change_out #(
    parameter int CREDIT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic [CREDIT_W-1:0] load_val_i,
    input  logic                ready_i,
    output logic                valid_o,
    output logic                empty_o,
    output logic                last_o
);

    logic [CREDIT_W-1:0] cnt_q, cnt_d;
    logic                valid_q;
    logic                take;

    assign take    = valid_q && ready_i;
    assign last_o  = take && (cnt_q == CREDIT_W'(1));
    assign empty_o = (cnt_q == '0);
    assign valid_o = valid_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (take) begin
            cnt_d = cnt_q - CREDIT_W'(1);
        end
    end

    // valid is kept as its own flop so the hopper sees a clean registered offer
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= (cnt_d != '0);
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// Multi-product vending controller: coin credit, per-product vend, cancel/refund.
// Optional macro VEND_TIMEOUT_EN adds an idle timer that triggers an automatic refund.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int                        N_PROD      = 2,
    parameter int                        PRICE_W     = 4,
    parameter logic [N_PROD*PRICE_W-1:0] PRICES      = {4'd5, 4'd3},
    parameter int                        CREDIT_W    = 4,
    parameter int                        MAX_CREDIT  = 9,
    parameter int                        TIMEOUT_CYC = 255,
    localparam int                       SEL_W       = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [COIN_W-1:0]   coin_val,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel_id,
    input  logic                cancel,
    output logic                drink_valid,
    output logic [SEL_W-1:0]    drink_id,
    output logic                reject,
    output logic                change_valid,
    input  logic                change_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    if (MAX_CREDIT >= (1 << CREDIT_W)) begin : g_chk_max
        $error("MAX_CREDIT does not fit in CREDIT_W bits");
    end
    for (genvar gi = 0; gi < N_PROD; gi++) begin : g_chk_price
        if (int'(PRICES[gi*PRICE_W +: PRICE_W]) > MAX_CREDIT) begin : g_bad
            $error("product price exceeds MAX_CREDIT");
        end
    end

    vend_state_t         state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic                drink_valid_q;
    logic [SEL_W-1:0]    drink_id_q;
    logic                reject_q;
    logic                busy_q;

    logic [CREDIT_W:0]   credit_ext, coin_sum, price_ext;
    logic [PRICE_W-1:0]  price_sel;
    logic [CREDIT_W-1:0] chg_load_val;
    logic                coin_raw_ok, coin_take, in_accept, cancel_eff;
    logic                sel_in_range, sel_take, chg_load, timeout;
    logic                chg_empty, chg_last;

    assign credit_ext  = {1'b0, credit_q};
    assign coin_sum    = credit_ext + (CREDIT_W+1)'(coin_val);
    assign in_accept   = (state_q == ST_IDLE) || (state_q == ST_CREDIT);
    assign coin_raw_ok = coin_valid && is_legal_coin(coin_val)
                         && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    assign cancel_eff  = (state_q == ST_CREDIT) && (cancel || timeout);
    assign coin_take   = coin_raw_ok && in_accept && !cancel_eff;

    always_comb begin
        price_sel    = '0;
        sel_in_range = 1'b0;
        for (int i = 0; i < N_PROD; i++) begin
            if (32'(sel_id) == i) begin
                price_sel    = PRICES[i*PRICE_W +: PRICE_W];
                sel_in_range = 1'b1;
            end
        end
    end

    assign price_ext = (CREDIT_W+1)'(price_sel);
    // a coin in the same cycle wins over the selection; keypad must reassert
    assign sel_take  = sel_valid && sel_in_range && (state_q == ST_CREDIT)
                       && (credit_ext >= price_ext) && !cancel_eff && !coin_valid;

    assign chg_load     = cancel_eff || sel_take;
    assign chg_load_val = cancel_eff ? credit_q : (credit_q - price_ext[CREDIT_W-1:0]);

`ifdef VEND_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMR_W-1:0] tmr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q <= TMR_W'(TIMEOUT_CYC);
        end else if ((state_q != ST_CREDIT) || coin_take || sel_valid) begin
            tmr_q <= TMR_W'(TIMEOUT_CYC);
        end else if (tmr_q != '0) begin
            tmr_q <= tmr_q - TMR_W'(1);
        end
    end

    // fires in the last of TIMEOUT_CYC consecutive idle cycles in CREDIT
    assign timeout = (state_q == ST_CREDIT) && (tmr_q == TMR_W'(1))
                     && !coin_raw_ok && !sel_valid;
`else
    assign timeout = 1'b0;
`endif

    vend_change_out #(
        .CREDIT_W (CREDIT_W)
    ) u_change (
        .clk        (clk),
        .rst        (rst),
        .load_i     (chg_load),
        .load_val_i (chg_load_val),
        .ready_i    (change_ready),
        .valid_o    (change_valid),
        .empty_o    (chg_empty),
        .last_o     (chg_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            drink_valid_q <= 1'b0;
            drink_id_q    <= '0;
            reject_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            drink_valid_q <= 1'b0;
            reject_q      <= coin_valid && !coin_take;
            case (state_q)
                ST_IDLE: begin
                    if (coin_take) begin
                        credit_q <= coin_sum[CREDIT_W-1:0];
                        state_q  <= ST_CREDIT;
                    end
                end
                ST_CREDIT: begin
                    if (cancel_eff) begin
                        credit_q <= '0;
                        state_q  <= ST_CHANGE;
                        busy_q   <= 1'b1;
                    end else if (coin_take) begin
                        credit_q <= coin_sum[CREDIT_W-1:0];
                    end else if (sel_take) begin
                        drink_valid_q <= 1'b1;
                        drink_id_q    <= sel_id;
                        credit_q      <= '0;
                        if (chg_load_val != '0) begin
                            state_q <= ST_CHANGE;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_CHANGE: begin
                    if (chg_last || chg_empty) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign credit      = credit_q;
    assign drink_valid = drink_valid_q;
    assign drink_id    = drink_id_q;
    assign reject      = reject_q;
    assign busy        = busy_q;

endmodule

// File: doc/vend_ctrl.md
# vend_ctrl

Parametrised multi-product vending controller. It is the successor to the two-drink, single-coin-pair sale block. It accumulates coin credit up to a configurable ceiling, vends one of `N_PROD` products at per-product prices, and supports cancel/refund. Change is returned one unit at a time over a valid/ready handshake, so the downstream coin hopper can stall the controller. It sits between the coin acceptor/keypad front end and the dispenser/hopper drivers.

## Interface
- `N_PROD`, default 2: number of products; `sel_id` width is `$clog2(N_PROD)`, minimum 1 bit.
- `PRICE_W`, default 4: width of one price field, in coin units.
- `PRICES`, default `{4'd5, 4'd3}`: packed `N_PROD*PRICE_W` vector; field `i` is the price of product `i`, so product0 = 3 and product1 = 5.
- `CREDIT_W`, default 4: width of the credit register and change counter.
- `MAX_CREDIT`, default 9: highest credit value the controller accepts.
- `TIMEOUT_CYC`, default 255: idle cycles before automatic refund; used only with `VEND_TIMEOUT_EN`.
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `coin_valid`, input, 1: a coin is presented this cycle.
- `coin_val`, input, 2: coin value in units; 1 and 2 are legal, 0 and 3 are illegal.
- `sel_valid`, input, 1: a product selection is presented this cycle.
- `sel_id`, input, `$clog2(N_PROD)`: selected product index.
- `cancel`, input, 1: refund request.
- `drink_valid`, output, 1: one-cycle vend pulse.
- `drink_id`, output, `$clog2(N_PROD)`: product index being vended; valid while `drink_valid` is high.
- `reject`, output, 1: one-cycle pulse; the coin presented in the previous cycle was not accepted.
- `change_valid`, output, 1: one change unit is offered.
- `change_ready`, input, 1: the hopper takes the offered unit.
- `credit`, output, `CREDIT_W`: current accumulated credit.
- `busy`, output, 1: high while the controller is in CHANGE.

## Operation
- States:
  - IDLE: credit is 0.
  - CREDIT: credit is greater than 0.
  - CHANGE: change remains to be paid out.
- Coin handling (IDLE or CREDIT only):
  - Coin accepted when `coin_val` is 1 or 2 and `credit + coin_val <= MAX_CREDIT`. Credit increases by `coin_val` and the state goes to CREDIT.
  - Any other coin, including one arriving in CHANGE, is rejected. Credit is unchanged and `reject` pulses.
- Selection (CREDIT only):
  - Accepted when `sel_id < N_PROD` and `credit >= PRICES[sel_id]`.
  - On acceptance, `drink_valid` pulses and `drink_id = sel_id`. Remainder = `credit - price`; credit is cleared.
  - Remainder greater than 0 goes to CHANGE; remainder of 0 goes to IDLE.
  - An insufficient or out-of-range selection is dropped with no state change and no pulse.
- Cancel (CREDIT only): the whole credit moves to the change counter and the state goes to CHANGE. Cancel in IDLE or CHANGE is ignored.
- Simultaneous events in one cycle:
  - `cancel` beats both coin and selection. The coin is rejected.
  - Coin plus selection, no cancel: the coin is processed and the selection is dropped. The keypad must reassert it.
- CHANGE:
  - `change_valid = 1` while the counter is greater than 0.
  - Each cycle with `change_valid && change_ready` decrements the counter by 1.
  - When the counter reaches 0 the state goes to IDLE.
  - Coins are rejected; selection and cancel are ignored.
- Arithmetic: all sums are computed in `CREDIT_W+1` bits and compared unsigned. `MAX_CREDIT` must be less than `2**CREDIT_W`, and every price must be at most `MAX_CREDIT`; both are elaborate-time assertions.

## Timing
- All outputs are registered. On `rst`: state IDLE, `credit` 0, `drink_valid`/`drink_id`/`reject`/`change_valid`/`busy` all 0.
- `credit`, `drink_valid`, `reject`, `change_valid` and `busy` update on the edge that samples the triggering input, so they are visible one cycle after that input.
- `change_valid` first asserts in the same cycle as `drink_valid`, or one cycle after a cancel.
- The offered unit is held while `change_ready` is low.
- After the last handshake, `change_valid` drops in the next cycle and the controller accepts coins in that cycle.
- Minimum turnaround for a vend with no change: one cycle.
- Reset in the middle of CHANGE discards the remaining change. The controller is in IDLE the cycle after `rst` is released.

## Configuration
- `VEND_TIMEOUT_EN` defined:
  - An idle counter runs in CREDIT and clears on any accepted coin or any `sel_valid`.
  - At `TIMEOUT_CYC` consecutive idle cycles the controller behaves exactly as if `cancel` were asserted.
- Not defined: the counter is absent, credit is held indefinitely, and `TIMEOUT_CYC` is ignored.

## Structure
- Package `vend_pkg` holds:
  - the state enum typedef `vend_state_t`;
  - the coin width constant `COIN_W = 2`;
  - the legal coin values.
- Sub-module `vend_change_out`: the change down-counter with valid/ready output, a load port and an empty flag. It is instantiated once.

## Test plan
- Coins 2 then 1, then `sel_id = 0`: `drink_valid` pulses with `drink_id = 0`, no `change_valid`, `credit = 0`.
- Coins 2, 2, 2, then `sel_id = 1`: vend of product 1, then `change_valid` with 1 unit. With `change_ready` low for 3 cycles, `change_valid` stays high. Raising `change_ready` gives one handshake and the controller returns to IDLE.
- Credit 2, `sel_id = 1`: no vend and credit stays 2. Credit 8 plus coin 2: `reject` pulses and credit stays 8. Coin value 3: `reject` pulses.
- Credit 4, coin 2 and `cancel` in the same cycle: `reject` pulses. With `change_ready` held high, 4 change units are paid over 4 consecutive cycles and `busy` is high for those 4 cycles.
- In CHANGE with 3 units left, assert `rst` for one cycle: the next cycle shows IDLE, credit 0 and `change_valid = 0`.
- Credit 1, `TIMEOUT_CYC = 16`, no input activity:
  - With `VEND_TIMEOUT_EN`: after 16 idle cycles the controller goes to CHANGE and pays 1 unit.
  - Without it: credit stays 1 indefinitely.
